// File: rtl/switch_box_pkg.sv
// Shared definitions for the configurable routing switch box: side codes,
// configuration FSM states and helpers that size the config frame.
package switch_box_pkg;

   // Source-side codes held in the upper field of every config word.
   typedef enum logic [2:0] {
      SIDE_OFF    = 3'd0,
      SIDE_TOP    = 3'd1,
      SIDE_RIGHT  = 3'd2,
      SIDE_BOTTOM = 3'd3,
      SIDE_LEFT   = 3'd4
   } side_e;

   // Highest legal side code; anything above it marks a corrupt frame.
   localparam int SIDE_MAX = 4;

   // Configuration loader states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } state_e;

   // Width of one per-wire config word.
   function automatic int calc_wordw(input int selw, input int idxw);
      return selw + idxw;
   endfunction

   // Data bits in one frame (parity bit excluded): one word per output wire.
   function automatic int calc_total(input int ntb, input int nlr,
                                     input int selw, input int idxw);
      return 2 * (ntb + nlr) * calc_wordw(selw, idxw);
   endfunction

endpackage

// File: rtl/switch_box_mux.sv
// One output wire of the switch box: decodes its config word and picks the
// selected source wire, or leaves the wire undriven when the side is off.
module switch_box_mux
   import switch_box_pkg::*;
#(
   parameter int NTB  = 5,
   parameter int NLR  = 4,
   parameter int IDXW = 3,
   parameter int SELW = 3
) (
   input  logic [SELW+IDXW-1:0] cfg,
   input  logic [NTB-1:0]       top_in,
   input  logic [NLR-1:0]       right_in,
   input  logic [NTB-1:0]       bottom_in,
   input  logic [NLR-1:0]       left_in,
   output logic                 out,
   output logic                 oe
);

   // Each side is widened to the full index range so any idx value selects
   // a defined bit; the loader never commits an out-of-range idx anyway.
   localparam int NPAD = 2 ** IDXW;

   logic [NPAD-1:0] top_pad;
   logic [NPAD-1:0] right_pad;
   logic [NPAD-1:0] bottom_pad;
   logic [NPAD-1:0] left_pad;
   logic [SELW-1:0] side;
   logic [IDXW-1:0] idx;

   assign top_pad    = NPAD'(top_in);
   assign right_pad  = NPAD'(right_in);
   assign bottom_pad = NPAD'(bottom_in);
   assign left_pad   = NPAD'(left_in);
   assign side       = cfg[SELW+IDXW-1:IDXW];
   assign idx        = cfg[IDXW-1:0];

   // Route the selected source wire to this output and enable the driver.
   always_comb begin
      // NOTE: defaults first, so every path assigns out/oe and no latch is inferred.
      out = 1'b0;
      oe  = 1'b0;
      case (side)
         SELW'(SIDE_TOP):    begin out = top_pad[idx];    oe = 1'b1; end
         SELW'(SIDE_RIGHT):  begin out = right_pad[idx];  oe = 1'b1; end
         SELW'(SIDE_BOTTOM): begin out = bottom_pad[idx]; oe = 1'b1; end
         SELW'(SIDE_LEFT):   begin out = left_pad[idx];   oe = 1'b1; end
         default:            ;
      endcase
   end

endmodule

// File: rtl/switch_box_cfg.sv
// FPGA routing switch box with a serially loaded, parity-checked,
// double-buffered configuration. Frames shift into a shadow register and are
// copied to the active register only after the whole frame validates.
module switch_box_cfg
   import switch_box_pkg::*;
#(
   parameter int NTB  = 5,
   parameter int NLR  = 4,
   parameter int IDXW = 3,
   parameter int SELW = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NTB-1:0] top_in,
   input  logic [NTB-1:0] bottom_in,
   input  logic [NLR-1:0] left_in,
   input  logic [NLR-1:0] right_in,
   output logic [NTB-1:0] top_out,
   output logic [NTB-1:0] bottom_out,
   output logic [NLR-1:0] left_out,
   output logic [NLR-1:0] right_out,
   output logic [NTB-1:0] top_oe,
   output logic [NTB-1:0] bottom_oe,
   output logic [NLR-1:0] left_oe,
   output logic [NLR-1:0] right_oe,
   input  logic           cfg_start,
   input  logic           cfg_valid,
   input  logic           cfg_bit,
   output logic           cfg_ready,
   output logic           cfg_busy,
   output logic           cfg_done,
   output logic           cfg_err
);

   localparam int WORDW = calc_wordw(SELW, IDXW);
   localparam int NWORD = 2 * (NTB + NLR);
   localparam int TOTAL = calc_total(NTB, NLR, SELW, IDXW);
   localparam int BEATW = $clog2(TOTAL + 1);
   localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(TOTAL);

   // Word k of a frame sits at [TOTAL-1-k*WORDW -: WORDW]: the first bit
   // shifted in ends up at the top. Word order is top, right, bottom, left.
   localparam int BASE_RIGHT  = NTB;
   localparam int BASE_BOTTOM = NTB + NLR;
   localparam int BASE_LEFT   = 2 * NTB + NLR;

   state_e           state;
   logic [BEATW-1:0] beat;
   logic [TOTAL-1:0] shadow;
   logic [TOTAL-1:0] active;
   logic             parity;

   logic [WORDW-1:0] word;
   int               s;
   int               i;
   int               own_s;
   int               own_i;
   logic             words_ok;
   logic             frame_ok;

   // Validate the completed shadow frame: legal sides, in-range indices,
   // no wire selecting itself, and even parity over data plus parity bit.
   always_comb begin
      words_ok = 1'b1;
      word     = '0;
      s        = 0;
      i        = 0;
      own_s    = 0;
      own_i    = 0;
      for (int k = 0; k < NWORD; k++) begin
         word = shadow[TOTAL-1-k*WORDW -: WORDW];
         s    = int'(word[WORDW-1:IDXW]);
         i    = int'(word[IDXW-1:0]);
         if (k < BASE_RIGHT) begin
            own_s = int'(SIDE_TOP);
            own_i = k;
         end else if (k < BASE_BOTTOM) begin
            own_s = int'(SIDE_RIGHT);
            own_i = k - BASE_RIGHT;
         end else if (k < BASE_LEFT) begin
            own_s = int'(SIDE_BOTTOM);
            own_i = k - BASE_BOTTOM;
         end else begin
            own_s = int'(SIDE_LEFT);
            own_i = k - BASE_LEFT;
         end
         if (s > SIDE_MAX) begin
            words_ok = 1'b0;
         end else if ((s == int'(SIDE_TOP) || s == int'(SIDE_BOTTOM)) && i >= NTB) begin
            words_ok = 1'b0;
         end else if ((s == int'(SIDE_RIGHT) || s == int'(SIDE_LEFT)) && i >= NLR) begin
            words_ok = 1'b0;
         end
         if (s == own_s && i == own_i) begin
            words_ok = 1'b0;
         end
      end
      frame_ok = words_ok && !parity;
   end

   // Loader FSM: shifts the frame in, checks it, then commits or flags an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: shadow and active are plain config registers, not a RAM; both are
         // reset so the box comes up with every wire undriven.
         state     <= ST_IDLE;
         beat      <= '0;
         shadow    <= '0;
         active    <= '0;
         parity    <= 1'b0;
         cfg_ready <= 1'b0;
         cfg_busy  <= 1'b0;
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register samples
         // pre-edge values no matter the statement order.
         cfg_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_start) begin
                  state     <= ST_SHIFT;
                  beat      <= '0;
                  parity    <= 1'b0;
                  cfg_err   <= 1'b0;
                  cfg_ready <= 1'b1;
                  cfg_busy  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (cfg_start) begin
                  // Restart wins over a simultaneous transfer; the bit is dropped.
                  beat   <= '0;
                  parity <= 1'b0;
               end else if (cfg_valid) begin
                  parity <= parity ^ cfg_bit;
                  if (beat == LAST_BEAT) begin
                     state     <= ST_CHECK;
                     cfg_ready <= 1'b0;
                  end else begin
                     shadow <= {shadow[TOTAL-2:0], cfg_bit};
                     beat   <= beat + BEATW'(1);
                  end
               end
            end
            ST_CHECK: begin
               if (frame_ok) begin
                  active   <= shadow;
                  cfg_done <= 1'b1;
               end else begin
                  cfg_err  <= 1'b1;
               end
               state    <= ST_IDLE;
               cfg_busy <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               cfg_ready <= 1'b0;
               cfg_busy  <= 1'b0;
            end
         endcase
      end
   end

   // One routing mux per output wire, fed from the active config.
   for (genvar j = 0; j < NTB; j++) begin : g_top
      switch_box_mux #(.NTB(NTB), .NLR(NLR), .IDXW(IDXW), .SELW(SELW)) u_mux (
         .cfg      (active[TOTAL-1-j*WORDW -: WORDW]),
         .top_in   (top_in),
         .right_in (right_in),
         .bottom_in(bottom_in),
         .left_in  (left_in),
         .out      (top_out[j]),
         .oe       (top_oe[j])
      );
   end

   for (genvar j = 0; j < NLR; j++) begin : g_right
      switch_box_mux #(.NTB(NTB), .NLR(NLR), .IDXW(IDXW), .SELW(SELW)) u_mux (
         .cfg      (active[TOTAL-1-(BASE_RIGHT+j)*WORDW -: WORDW]),
         .top_in   (top_in),
         .right_in (right_in),
         .bottom_in(bottom_in),
         .left_in  (left_in),
         .out      (right_out[j]),
         .oe       (right_oe[j])
      );
   end

   for (genvar j = 0; j < NTB; j++) begin : g_bottom
      switch_box_mux #(.NTB(NTB), .NLR(NLR), .IDXW(IDXW), .SELW(SELW)) u_mux (
         .cfg      (active[TOTAL-1-(BASE_BOTTOM+j)*WORDW -: WORDW]),
         .top_in   (top_in),
         .right_in (right_in),
         .bottom_in(bottom_in),
         .left_in  (left_in),
         .out      (bottom_out[j]),
         .oe       (bottom_oe[j])
      );
   end

   for (genvar j = 0; j < NLR; j++) begin : g_left
      switch_box_mux #(.NTB(NTB), .NLR(NLR), .IDXW(IDXW), .SELW(SELW)) u_mux (
         .cfg      (active[TOTAL-1-(BASE_LEFT+j)*WORDW -: WORDW]),
         .top_in   (top_in),
         .right_in (right_in),
         .bottom_in(bottom_in),
         .left_in  (left_in),
         .out      (left_out[j]),
         .oe       (left_oe[j])
      );
   end

endmodule

// File: tb/tb_switch_box_cfg.sv
// Directed bench for switch_box_cfg: routing vector table plus hand-written
// frame sequences for commit, rejection, restart, gaps and mid-frame reset.
module tb_switch_box_cfg;

   localparam int NTB   = 5;
   localparam int NLR   = 4;
   localparam int WORDW = 6;
   localparam int NWORD = 18;
   localparam int TOTAL = 108;

   logic           clk;
   logic           rst_n;
   logic [NTB-1:0] top_in, bottom_in;
   logic [NLR-1:0] left_in, right_in;
   logic [NTB-1:0] top_out, bottom_out, top_oe, bottom_oe;
   logic [NLR-1:0] left_out, right_out, left_oe, right_oe;
   logic           cfg_start, cfg_valid, cfg_bit;
   logic           cfg_ready, cfg_busy, cfg_done, cfg_err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [4:0] t_in;  logic [3:0] r_in;  logic [4:0] b_in;  logic [3:0] l_in;
      logic [4:0] t_out; logic [3:0] r_out; logic [4:0] b_out; logic [3:0] l_out;
      logic [4:0] t_oe;  logic [3:0] r_oe;  logic [4:0] b_oe;  logic [3:0] l_oe;
   } vec_t;

   vec_t       vecs[11];
   logic [5:0] cfg_w[NWORD];

   switch_box_cfg dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .top_in    (top_in),
      .bottom_in (bottom_in),
      .left_in   (left_in),
      .right_in  (right_in),
      .top_out   (top_out),
      .bottom_out(bottom_out),
      .left_out  (left_out),
      .right_out (right_out),
      .top_oe    (top_oe),
      .bottom_oe (bottom_oe),
      .left_oe   (left_oe),
      .right_oe  (right_oe),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_bit   (cfg_bit),
      .cfg_ready (cfg_ready),
      .cfg_busy  (cfg_busy),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] mk(input int side, input int idx);
      return {3'(side), 3'(idx)};
   endfunction

   task automatic clear_cfg();
      for (int k = 0; k < NWORD; k++) cfg_w[k] = 6'd0;
   endtask

   task automatic apply_vectors(input int first, input int last);
      for (int v = first; v <= last; v++) begin
         @(negedge clk);
         top_in    = vecs[v].t_in;
         right_in  = vecs[v].r_in;
         bottom_in = vecs[v].b_in;
         left_in   = vecs[v].l_in;
         #1;
         check($sformatf("v%0d_top_out", v),    32'(top_out),    32'(vecs[v].t_out));
         check($sformatf("v%0d_right_out", v),  32'(right_out),  32'(vecs[v].r_out));
         check($sformatf("v%0d_bottom_out", v), 32'(bottom_out), 32'(vecs[v].b_out));
         check($sformatf("v%0d_left_out", v),   32'(left_out),   32'(vecs[v].l_out));
         check($sformatf("v%0d_top_oe", v),     32'(top_oe),     32'(vecs[v].t_oe));
         check($sformatf("v%0d_right_oe", v),   32'(right_oe),   32'(vecs[v].r_oe));
         check($sformatf("v%0d_bottom_oe", v),  32'(bottom_oe),  32'(vecs[v].b_oe));
         check($sformatf("v%0d_left_oe", v),    32'(left_oe),    32'(vecs[v].l_oe));
      end
   endtask

   // Offer one bit; returns after the negedge preceding the accepting posedge.
   task automatic send_bit(input logic b, input int gap_pct);
      int gaps = 0;
      while (gap_pct > 0 && gaps < 8 && $urandom_range(0, 99) < gap_pct) begin
         @(negedge clk);
         cfg_valid = 1'b0;
         gaps++;
      end
      for (int t = 0; t < 16; t++) begin
         @(negedge clk);
         cfg_valid = 1'b1;
         cfg_bit   = b;
         if (cfg_ready) return;
      end
      $display("FAIL cfg_ready_timeout: got 0, expected 1 within 16 cycles");
      $fatal(1, "cfg_ready timeout");
   endtask

   // Start a frame built from cfg_w and send `limit` beats (-1 = whole frame).
   task automatic send_frame(input logic flip_par, input int gap_pct,
                             input int limit, input logic start_with_valid);
      logic [TOTAL-1:0] stream;
      logic             par;
      int               n_beats;
      for (int k = 0; k < NWORD; k++)
         for (int b = 0; b < WORDW; b++)
            stream[k*WORDW + b] = cfg_w[k][WORDW-1-b];
      par     = (^stream) ^ flip_par;
      n_beats = (limit < 0) ? TOTAL + 1 : limit;
      @(negedge clk);
      cfg_start = 1'b1;
      if (start_with_valid) begin
         cfg_valid = 1'b1;
         cfg_bit   = 1'b1;
      end
      @(negedge clk);
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      for (int n = 0; n < n_beats; n++)
         send_bit((n == TOTAL) ? par : stream[n], gap_pct);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // Called in the CHECK cycle right after the parity beat was taken.
   task automatic finish_frame(input logic exp_ok, input logic start_in_check);
      check("check_busy",  32'(cfg_busy),  32'd1);
      check("check_ready", 32'(cfg_ready), 32'd0);
      check("check_done",  32'(cfg_done),  32'd0);
      if (start_in_check) cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      check("result_done", 32'(cfg_done), 32'(exp_ok));
      check("result_err",  32'(cfg_err),  32'(!exp_ok));
      check("result_busy", 32'(cfg_busy), 32'd0);
      @(negedge clk);
      check("done_pulse_end", 32'(cfg_done), 32'd0);
   endtask

   initial begin
      // Reset phase: every output undriven and zero.
      vecs[0]  = '{5'h1F, 4'hF, 5'h1F, 4'hF, 5'h00, 4'h0, 5'h00, 4'h0, 5'h00, 4'h0, 5'h00, 4'h0};
      vecs[1]  = '{5'h15, 4'hA, 5'h0A, 4'h5, 5'h00, 4'h0, 5'h00, 4'h0, 5'h00, 4'h0, 5'h00, 4'h0};
      vecs[2]  = '{5'h00, 4'h0, 5'h00, 4'h0, 5'h00, 4'h0, 5'h00, 4'h0, 5'h00, 4'h0, 5'h00, 4'h0};
      // Frame A: top[0] <- left[2], right[3] <- bottom[4].
      vecs[3]  = '{5'h1F, 4'hF, 5'h00, 4'h0, 5'h00, 4'h0, 5'h00, 4'h0, 5'h01, 4'h8, 5'h00, 4'h0};
      vecs[4]  = '{5'h00, 4'h0, 5'h10, 4'h4, 5'h01, 4'h8, 5'h00, 4'h0, 5'h01, 4'h8, 5'h00, 4'h0};
      vecs[5]  = '{5'h1F, 4'hF, 5'h0F, 4'hB, 5'h00, 4'h0, 5'h00, 4'h0, 5'h01, 4'h8, 5'h00, 4'h0};
      vecs[6]  = '{5'h00, 4'h0, 5'h10, 4'h0, 5'h00, 4'h8, 5'h00, 4'h0, 5'h01, 4'h8, 5'h00, 4'h0};
      vecs[7]  = '{5'h00, 4'h0, 5'h0F, 4'h4, 5'h01, 4'h0, 5'h00, 4'h0, 5'h01, 4'h8, 5'h00, 4'h0};
      // Frame E: bottom[1] <- top[4], left[3] <- right[0].
      vecs[8]  = '{5'h10, 4'h1, 5'h1F, 4'hF, 5'h00, 4'h0, 5'h02, 4'h8, 5'h00, 4'h0, 5'h02, 4'h8};
      vecs[9]  = '{5'h0F, 4'hE, 5'h00, 4'h0, 5'h00, 4'h0, 5'h00, 4'h0, 5'h00, 4'h0, 5'h02, 4'h8};
      vecs[10] = '{5'h10, 4'hE, 5'h00, 4'h0, 5'h00, 4'h0, 5'h02, 4'h0, 5'h00, 4'h0, 5'h02, 4'h8};

      rst_n = 1'b0;
      cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
      top_in = '0; bottom_in = '0; left_in = '0; right_in = '0;
      repeat (3) @(negedge clk);
      top_in    = 5'($urandom);
      bottom_in = 5'($urandom);
      left_in   = 4'($urandom);
      right_in  = 4'($urandom);
      #1;
      check("rst_oe",    32'({top_oe, right_oe, bottom_oe, left_oe}),     32'd0);
      check("rst_out",   32'({top_out, right_out, bottom_out, left_out}), 32'd0);
      check("rst_ready", 32'(cfg_ready), 32'd0);
      check("rst_busy",  32'(cfg_busy),  32'd0);
      check("rst_done",  32'(cfg_done),  32'd0);
      check("rst_err",   32'(cfg_err),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_vectors(0, 2);

      // Frame A commits.
      clear_cfg();
      cfg_w[0] = mk(4, 2);
      cfg_w[8] = mk(3, 4);
      send_frame(1'b0, 0, -1, 1'b0);
      finish_frame(1'b1, 1'b0);
      apply_vectors(3, 7);

      // Same frame, parity flipped: rejected, frame A still routes.
      send_frame(1'b1, 0, -1, 1'b0);
      finish_frame(1'b0, 1'b0);
      apply_vectors(3, 7);

      // left[1] <- right[4]: index beyond NLR.
      clear_cfg();
      cfg_w[15] = mk(2, 4);
      send_frame(1'b0, 0, -1, 1'b0);
      finish_frame(1'b0, 1'b0);
      apply_vectors(4, 5);

      // top[2] <- top[2]: self selection.
      clear_cfg();
      cfg_w[2] = mk(1, 2);
      send_frame(1'b0, 0, -1, 1'b0);
      finish_frame(1'b0, 1'b0);
      apply_vectors(4, 5);

      // 50 beats of a partial frame, then a restart (with a valid bit in the
      // same cycle) carrying frame E. Only frame E may commit.
      clear_cfg();
      cfg_w[0] = mk(4, 1);
      send_frame(1'b0, 0, 50, 1'b0);
      check("partial_busy",    32'(cfg_busy), 32'd1);
      check("partial_err_clr", 32'(cfg_err),  32'd0);
      clear_cfg();
      cfg_w[10] = mk(1, 4);
      cfg_w[17] = mk(2, 0);
      send_frame(1'b0, 0, -1, 1'b1);
      finish_frame(1'b1, 1'b0);
      check("restart_err", 32'(cfg_err), 32'd0);
      apply_vectors(8, 10);

      // Frame A with ~30% valid gaps; a cfg_start during CHECK is ignored.
      clear_cfg();
      cfg_w[0] = mk(4, 2);
      cfg_w[8] = mk(3, 4);
      send_frame(1'b0, 30, -1, 1'b0);
      finish_frame(1'b1, 1'b1);
      apply_vectors(3, 7);

      // Reset in the middle of a frame clears the active config.
      clear_cfg();
      cfg_w[10] = mk(1, 4);
      send_frame(1'b0, 0, 40, 1'b0);
      check("midframe_busy", 32'(cfg_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_oe",    32'({top_oe, right_oe, bottom_oe, left_oe}), 32'd0);
      check("midrst_ready", 32'(cfg_ready), 32'd0);
      check("midrst_busy",  32'(cfg_busy),  32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      cfg_valid = 1'b1;
      @(negedge clk);
      check("idle_ready", 32'(cfg_ready), 32'd0);
      check("idle_busy",  32'(cfg_busy),  32'd0);
      cfg_valid = 1'b0;
      apply_vectors(0, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
